// File: rtl/bcd_interval_timer.sv
// BCD MM..M:SS interval timer with built-in prescaler, up/down counting and optional auto-reload.
// All outputs registered; state/count change one cycle after the causing strobe or tick.
module bcd_interval_timer #(
  parameter int CLK_DIV     = 50000000,
  parameter int MIN_DIGITS  = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                        CLOCK_50_i,
  input  logic                        reset_i,
  input  logic                        load_i,
  input  logic [4*(MIN_DIGITS+2)-1:0] load_value_i,
  input  logic                        mode_up_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  output logic [4*(MIN_DIGITS+2)-1:0] count_o,
  output logic [1:0]                  state_o,
  output logic                        running_o,
  output logic                        expired_o,
  output logic                        flash_o
);

  localparam int ND = MIN_DIGITS + 2;
  localparam int W  = 4 * ND;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Seconds-tens digit rolls at 5, every other digit at 9.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 1) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  target_q, target_d;
  logic [W-1:0]  reload_q, reload_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_up_q, mode_up_d;
  logic          expired_q, expired_d;
  logic          flash_q, flash_d;
  logic          running_q, running_d;

  logic          tick;
  logic          terminal_now;
  logic [W-1:0]  load_san;
  logic [W-1:0]  count_inc;
  logic [W-1:0]  count_dec;

  always_ff @(posedge CLOCK_50_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      target_q  <= '0;
      reload_q  <= '0;
      presc_q   <= '0;
      mode_up_q <= 1'b0;
      expired_q <= 1'b0;
      flash_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      mode_up_q <= mode_up_d;
      expired_q <= expired_d;
      flash_q   <= flash_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    reload_d  = reload_q;
    presc_d   = presc_q;
    mode_up_d = mode_up_q;
    expired_d = 1'b0;
    flash_d   = flash_q;

    tick         = ((state_q == S_RUN) || (state_q == S_DONE)) && (presc_q == PRESC_MAX);
    terminal_now = mode_up_q ? (count_q == target_q) : (count_q == '0);
    load_san     = sanitise(load_value_i);
    count_inc    = bcd_inc(count_q);
    count_dec    = bcd_dec(count_q);

    if (load_i) begin
      state_d   = S_IDLE;
      presc_d   = '0;
      flash_d   = 1'b0;
      mode_up_d = mode_up_i;
      if (mode_up_i) begin
        target_d = load_san;
        count_d  = '0;
      end else begin
        count_d  = load_san;
        reload_d = load_san;
      end
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          // A simultaneous stop suppresses start outside RUN as well.
          if (start_i && !stop_i) begin
            presc_d = '0;
            if (terminal_now) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (stop_i) begin
            state_d = S_PAUSE;
          end else if (!tick) begin
            presc_d = presc_q + 1'b1;
          end else begin
            presc_d = '0;
            if (mode_up_q) begin
              count_d = count_inc;
              if (count_inc == target_q) begin
                expired_d = 1'b1;
                state_d   = S_DONE;
              end
            end else if (count_q == '0) begin
              // Only reachable with auto-reload: the tick after expiry restarts the interval.
              if (reload_q == '0) state_d = S_DONE;
              else                count_d = reload_q;
            end else begin
              count_d = count_dec;
              if (count_dec == '0) begin
                expired_d = 1'b1;
                if (AUTO_RELOAD == 0) state_d = S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (tick) begin
            presc_d = '0;
            flash_d = ~flash_q;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    running_d = (state_d == S_RUN);
  end

  assign count_o   = count_q;
  assign state_o   = state_q;
  assign running_o = running_q;
  assign expired_o = expired_q;
  assign flash_o   = flash_q;

endmodule

// File: tb/tb_bcd_interval_timer.sv
// Drives one timer without and one with auto-reload from shared stimulus; a seconds-based
// reference model predicts every output each cycle.
module tb_bcd_interval_timer;

  localparam int CLK_DIV    = 4;
  localparam int MIN_DIGITS = 2;
  localparam int W          = 4 * (MIN_DIGITS + 2);

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, ld, up_in, st_in, sp_in;
  logic [W-1:0] val;

  logic [W-1:0] cnt0, cnt1;
  logic [1:0]   sta0, sta1;
  logic         run0, run1, exp0, exp1, fl0, fl1;

  bcd_interval_timer #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(MIN_DIGITS), .AUTO_RELOAD(0)) dut0 (
    .CLOCK_50_i(clk), .reset_i(rst), .load_i(ld), .load_value_i(val), .mode_up_i(up_in),
    .start_i(st_in), .stop_i(sp_in), .count_o(cnt0), .state_o(sta0), .running_o(run0),
    .expired_o(exp0), .flash_o(fl0)
  );

  bcd_interval_timer #(.CLK_DIV(CLK_DIV), .MIN_DIGITS(MIN_DIGITS), .AUTO_RELOAD(1)) dut1 (
    .CLOCK_50_i(clk), .reset_i(rst), .load_i(ld), .load_value_i(val), .mode_up_i(up_in),
    .start_i(st_in), .stop_i(sp_in), .count_o(cnt1), .state_o(sta1), .running_o(run1),
    .expired_o(exp1), .flash_o(fl1)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: time is tracked as whole seconds, the prescaler as cycles since last clear.
  int m_st[2], m_secs[2], m_tgt[2], m_rel[2], m_cyc[2];
  bit m_up[2], m_exp[2], m_fl[2];

  function automatic int value_to_secs(input logic [W-1:0] v);
    int d[4];
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(v[4*i +: 4]);
      if (i == 1 && d[i] > 5) d[i] = 0;
      if (i != 1 && d[i] > 9) d[i] = 0;
    end
    return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
  endfunction

  function automatic logic [W-1:0] secs_to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic model_reset(input int k);
    m_st[k] = S_IDLE; m_secs[k] = 0; m_tgt[k] = 0; m_rel[k] = 0;
    m_cyc[k] = 0; m_up[k] = 1'b0; m_exp[k] = 1'b0; m_fl[k] = 1'b0;
  endtask

  task automatic model_step(input int k, input bit auto_reload);
    int v;
    m_exp[k] = 1'b0;
    if (rst) begin
      model_reset(k);
    end else if (ld) begin
      v        = value_to_secs(val);
      m_st[k]  = S_IDLE;
      m_cyc[k] = 0;
      m_fl[k]  = 1'b0;
      m_up[k]  = up_in;
      if (up_in) begin
        m_tgt[k]  = v;
        m_secs[k] = 0;
      end else begin
        m_secs[k] = v;
        m_rel[k]  = v;
      end
    end else if (m_st[k] == S_IDLE || m_st[k] == S_PAUSE) begin
      if (st_in && !sp_in) begin
        m_cyc[k] = 0;
        if (m_up[k] ? (m_secs[k] == m_tgt[k]) : (m_secs[k] == 0)) begin
          m_st[k]  = S_DONE;
          m_exp[k] = 1'b1;
        end else begin
          m_st[k] = S_RUN;
        end
      end
    end else if (m_st[k] == S_RUN) begin
      if (sp_in) begin
        m_st[k] = S_PAUSE;
      end else begin
        m_cyc[k]++;
        if (m_cyc[k] == CLK_DIV) begin
          m_cyc[k] = 0;
          if (m_up[k]) begin
            m_secs[k]++;
            if (m_secs[k] == m_tgt[k]) begin
              m_exp[k] = 1'b1;
              m_st[k]  = S_DONE;
            end
          end else if (m_secs[k] == 0) begin
            if (m_rel[k] == 0) m_st[k] = S_DONE;
            else               m_secs[k] = m_rel[k];
          end else begin
            m_secs[k]--;
            if (m_secs[k] == 0) begin
              m_exp[k] = 1'b1;
              if (!auto_reload) m_st[k] = S_DONE;
            end
          end
        end
      end
    end else begin
      m_cyc[k]++;
      if (m_cyc[k] == CLK_DIV) begin
        m_cyc[k] = 0;
        m_fl[k]  = !m_fl[k];
      end
    end
  endtask

  task automatic compare_all();
    chk("ar0 count",   32'(cnt0), 32'(secs_to_bcd(m_secs[0])));
    chk("ar0 state",   32'(sta0), 32'(m_st[0]));
    chk("ar0 running", 32'(run0), 32'(m_st[0] == S_RUN));
    chk("ar0 expired", 32'(exp0), 32'(m_exp[0]));
    chk("ar0 flash",   32'(fl0),  32'(m_fl[0]));
    chk("ar1 count",   32'(cnt1), 32'(secs_to_bcd(m_secs[1])));
    chk("ar1 state",   32'(sta1), 32'(m_st[1]));
    chk("ar1 running", 32'(run1), 32'(m_st[1] == S_RUN));
    chk("ar1 expired", 32'(exp1), 32'(m_exp[1]));
    chk("ar1 flash",   32'(fl1),  32'(m_fl[1]));
  endtask

  task automatic cycle(input logic r, input logic l, input logic [W-1:0] v,
                       input logic u, input logic s, input logic p);
    @(negedge clk);
    rst = r; ld = l; val = v; up_in = u; st_in = s; sp_in = p;
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_run(input logic [W-1:0] v, input logic u);
    cycle(1'b0, 1'b1, v, u, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rv;
    model_reset(0);
    model_reset(1);
    rst = 1'b1; ld = 1'b0; val = '0; up_in = 1'b0; st_in = 1'b0; sp_in = 1'b0;

    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0042, 1'b1, 1'b1, 1'b0);

    load_run(16'h0012, 1'b0);  idle(60);
    load_run(16'h0100, 1'b0);  idle(6);
    load_run(16'h1000, 1'b0);  idle(6);
    cycle(1'b0, 1'b1, 16'h07A9, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0060, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);  idle(3);
    load_run(16'h0003, 1'b1);  idle(4);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);  idle(20);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);  idle(20);
    load_run(16'h0002, 1'b0);  idle(30);
    cycle(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);  idle(2);
    load_run(16'h0030, 1'b0);  idle(10);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);  idle(2);
    load_run(16'h0000, 1'b1);  idle(10);
    load_run(16'h9959, 1'b1);  idle(12);

    for (int n = 0; n < 15000; n++) begin
      if ($urandom_range(0, 3) == 0) rv = W'($urandom);
      else rv = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 11))};
      cycle($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 3, rv, 1'($urandom),
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
